// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// 32 lines x 32 B; address split tag[31:10], index[9:5], word[4:2].
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAG_W  = 22;
  localparam int unsigned WORD_W = 3;
  localparam int unsigned LINE_W = 256;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_MISS       = 3'd1;
  localparam logic [2:0] S_WRITEBACK  = 3'd2;
  localparam logic [2:0] S_READMISS   = 3'd3;
  localparam logic [2:0] S_READMISSOK = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WORD_W-1:0] word;
  logic              req, is_write, is_read, hit;
  logic [LINE_W-1:0] line_rd;
  logic [LINE_W-1:0] line_d;
  logic              line_we, tag_we;
  logic              byte_off_unused;

  assign idx             = cpu_addr_i[9:5];
  assign cpu_tag         = cpu_addr_i[31:10];
  assign word            = cpu_addr_i[4:2];
  assign byte_off_unused = ^cpu_addr_i[1:0];
  assign req             = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_write        = cpu_MemWrite_i;
  assign is_read         = cpu_MemRead_i & ~cpu_MemWrite_i;
  assign line_rd         = data_q[idx];
  assign hit             = valid_q[idx] & (tag_q[idx] == cpu_tag);

  // State, valid and dirty registers; reset clears only the status bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays; written on store hits and on refill acks.
  always_ff @(posedge clk_i) begin
    if (line_we) data_q[idx] <= line_d;
    if (tag_we)  tag_q[idx]  <= cpu_tag;
  end

  // Next-state, array write controls and the combinational port outputs.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_d       = line_rd;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    cpu_data_o   = 32'b0;
    cpu_stall_o  = req & (~hit | (state_q != S_IDLE));
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'b0;
    mem_data_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (is_write) begin
              line_d[{word, 5'b0} +: 32] = cpu_data_i;
              line_we                    = 1'b1;
              dirty_d[idx]               = 1'b1;
            end else if (is_read) begin
              cpu_data_o = line_rd[{word, 5'b0} +: 32];
            end
          end else begin
            state_d = S_MISS;
          end
        end
      end
      S_MISS: begin
        state_d = (valid_q[idx] & dirty_q[idx]) ? S_WRITEBACK : S_READMISS;
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = line_rd;
        if (mem_ack_i) state_d = S_READMISS;
      end
      S_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_tag, idx, 5'b0};
        if (mem_ack_i) begin
          line_d       = mem_data_i;
          line_we      = 1'b1;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = S_READMISSOK;
        end
      end
      S_READMISSOK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a word-level write-back cache model
// predicts load data, stall length and memory traffic; monitors compare.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_MemRead_i (cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          stall;
  } sb_t;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] data;
  } mt_t;

  sb_t sb_q[$];
  mt_t mt_q[$];

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int stall_cnt = 0;
  int mem_cnt   = 0;
  int k_lat     = 10;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          m_valid [32];
  bit          m_dirty [32];
  logic [21:0] m_tag   [32];
  logic [31:0] m_line  [32][8];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : pat(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a write-back write-allocate cache over a flat word memory.
  task automatic model_access(input logic [31:0] a, input logic [31:0] d, input bit wr,
                              output sb_t e);
    logic [4:0]   idx;
    logic [21:0]  tg;
    logic [2:0]   w;
    logic [31:0]  va, na;
    logic [255:0] blk;
    int           stall;
    idx   = a[9:5];
    tg    = a[31:10];
    w     = a[4:2];
    stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        va  = {m_tag[idx], idx, 5'b0};
        blk = '0;
        for (int i = 0; i < 8; i++) begin
          ref_mem[va + 32'(i * 4)] = m_line[idx][i];
          blk[32*i +: 32]          = m_line[idx][i];
        end
        mt_q.push_back('{we: 1'b1, addr: va, data: blk});
        stall += k_lat;
      end
      na = {tg, idx, 5'b0};
      for (int i = 0; i < 8; i++) m_line[idx][i] = ref_rd(na + 32'(i * 4));
      mt_q.push_back('{we: 1'b0, addr: na, data: '0});
      stall       += k_lat + 3;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (wr) begin
      m_line[idx][w] = d;
      m_dirty[idx]   = 1'b1;
      e.data         = 32'b0;
    end else begin
      e.data = m_line[idx][w];
    end
    e.rd    = !wr;
    e.stall = stall;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Drive one access and hold it until the monitor sees it complete.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr);
    sb_t e;
    int  prev;
    bit  ok;
    model_access(a, d, wr, e);
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    cpu_addr_i     = a;
    cpu_data_i     = d;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    prev = done_cnt;
    ok   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i);
      if (done_cnt != prev) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: addr %h never completed", a);
      sb_q.delete();
    end
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  // Monitor: count stall cycles, compare when the access completes.
  always @(negedge clk_i) begin
    sb_t e;
    if (!rst_i || !(cpu_MemRead_i || cpu_MemWrite_i)) begin
      stall_cnt = 0;
    end else if (cpu_stall_o) begin
      stall_cnt++;
    end else begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completion: addr %h", cpu_addr_i);
      end else begin
        e = sb_q.pop_front();
        check("stall_cycles", 256'(stall_cnt), 256'(e.stall));
        check("load_data", 256'(cpu_data_o), 256'(e.data));
      end
      done_cnt++;
      stall_cnt = 0;
    end
  end

  // Memory: ack in the k_lat-th enable cycle; stray acks while idle.
  always @(negedge clk_i) begin
    mt_t x;
    logic [255:0] blk;
    mem_ack_i = 1'b0;
    if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt >= k_lat) begin
        mem_cnt   = 0;
        mem_ack_i = 1'b1;
        if (mt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_txn: addr %h we %b", mem_addr_o, mem_write_o);
        end else begin
          x = mt_q.pop_front();
          check("mem_write", 256'(mem_write_o), 256'(x.we));
          check("mem_addr", 256'(mem_addr_o), 256'(x.addr));
          if (x.we) check("wb_data", mem_data_o, x.data);
        end
        if (mem_write_o) begin
          for (int i = 0; i < 8; i++) dev_mem[mem_addr_o + 32'(i * 4)] = mem_data_o[32*i +: 32];
        end else begin
          blk = '0;
          for (int i = 0; i < 8; i++) blk[32*i +: 32] = dev_rd(mem_addr_o + 32'(i * 4));
          mem_data_i = blk;
        end
      end
    end else begin
      mem_cnt = 0;
      if ($urandom_range(0, 7) == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom}};
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    sb_t         dummy;
    logic [31:0] a;
    int          r;

    rst_i          = 1'b0;
    cpu_addr_i     = 32'h0000_0004;
    cpu_data_i     = 32'b0;
    cpu_MemRead_i  = 1'b1;
    cpu_MemWrite_i = 1'b0;
    mem_data_i     = '0;
    mem_ack_i      = 1'b0;
    model_reset();

    // Reset state: no line can hit, memory side idle.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stall", 256'(cpu_stall_o), 256'(1));
    check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data", mem_data_o, 256'(0));
    check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
    cpu_MemRead_i = 1'b0;
    #1;
    check("rst_stall_noreq", 256'(cpu_stall_o), 256'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Directed sequence at K = Kw = 10.
    k_lat = 10;
    issue(32'h0000_0004, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0004, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(32'h0000_0008, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0408, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0800, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0804, 32'h1234_5678, 1'b1, 1'b1);
    issue(32'h0000_0804, 32'h0, 1'b1, 1'b0);

    // Request withdrawn mid-miss: refill still completes, later load hits.
    model_access(32'h0000_1020, 32'h0, 1'b0, dummy);
    @(posedge clk_i);
    #1;
    cpu_addr_i    = 32'h0000_1020;
    cpu_MemRead_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    repeat (40) @(posedge clk_i);
    issue(32'h0000_1020, 32'h0, 1'b1, 1'b0);

    // Reset in the fifth READMISS cycle of a dirty eviction.
    model_access(32'h0000_0C00, 32'h0, 1'b0, dummy);
    @(posedge clk_i);
    #1;
    cpu_addr_i    = 32'h0000_0C00;
    cpu_MemRead_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 5; c++) begin
      @(posedge clk_i);
      #1;
      if (mem_enable_o && !mem_write_o) cnt++;
    end
    check("readmiss_reached", 256'(cnt), 256'(5));
    rst_i = 1'b0;
    #1;
    check("midrst_enable", 256'(mem_enable_o), 256'(0));
    check("midrst_addr", 256'(mem_addr_o), 256'(0));
    check("midrst_stall", 256'(cpu_stall_o), 256'(1));
    mt_q.delete();
    model_reset();
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    issue(32'h0000_0C00, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_0804, 32'h0, 1'b1, 1'b0);

    // Randomized traffic over a few aliasing tags and indices.
    for (int n = 0; n < 300; n++) begin
      k_lat = $urandom_range(1, 6);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFC0_0000;
      r = $urandom_range(0, 9);
      if (r < 5)      issue(a, 32'h0, 1'b1, 1'b0);
      else if (r < 9) issue(a, $urandom, 1'b0, 1'b1);
      else            issue(a, $urandom, 1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (5) @(posedge clk_i);
    check("sb_drained", 256'(sb_q.size()), 256'(0));
    check("mem_txn_drained", 256'(mt_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
